traffic_phase_ctrl: RTL and testbench

Parametrised multi-phase traffic signal controller: the generalised successor of the fixed two-road sequencer. It drives N_SIG signal heads through N_PHASE configurable phases. Each phase runs red+yellow, green, yellow and all-red intervals. The block adds per-phase runtime green times, demand-based phase skipping and emergency preemption. It sits between the intersection timing/config registers and the lamp drivers.

---
 rtl/traffic_phase_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Multi-phase traffic signal controller.
// Walks N_PHASE phases through REDYEL -> GREEN -> YELLOW -> ALLRED, with
// per-phase runtime green times, demand-based phase skipping and
// emergency preemption into an all-red HOLD state.
module traffic_phase_ctrl #(
  parameter int                       N_SIG      = 4,
  parameter int                       N_PHASE    = 4,
  parameter int                       CNT_W      = 6,
  parameter logic [N_PHASE*N_SIG-1:0] PHASE_MASK = 16'h18C3,
  parameter int                       ALLRED_T   = 1,
  parameter int                       REDYEL_T   = 2,
  parameter int                       YELLOW_T   = 2,
  parameter bit                       SKIP_EN    = 1'b1,
  parameter int                       PH_W       = (N_PHASE > 1) ? $clog2(N_PHASE) : 1
) (
  input  logic                       clk,
  input  logic                       Rst,
  input  logic                       Go,
  input  logic [N_PHASE*CNT_W-1:0]   green_time,
  input  logic [N_PHASE-1:0]         req,
  input  logic                       preempt,
  output logic [2*N_SIG-1:0]         sig,
  output logic [PH_W-1:0]            phase,
  output logic [2:0]                 state,
  output logic                       phase_done
);

  localparam logic [2:0] S_ALLRED = 3'd0;
  localparam logic [2:0] S_REDYEL = 3'd1;
  localparam logic [2:0] S_GREEN  = 3'd2;
  localparam logic [2:0] S_YELLOW = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  // Last timer value of each fixed interval; a zero duration behaves as one cycle.
  localparam logic [CNT_W-1:0] AR_LAST = (ALLRED_T <= 1) ? '0 : CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] RY_LAST = (REDYEL_T <= 1) ? '0 : CNT_W'(REDYEL_T - 1);
  localparam logic [CNT_W-1:0] YE_LAST = (YELLOW_T <= 1) ? '0 : CNT_W'(YELLOW_T - 1);
  localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(N_PHASE - 1);
  localparam logic [PH_W:0]    N_PHASE_EXT = (PH_W + 1)'(N_PHASE);

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic [PH_W-1:0]  phase_reg, phase_next;
  logic [CNT_W-1:0] g_reg, g_next;
  logic             phase_done_reg, phase_done_next;

  logic             advance;
  logic [CNT_W-1:0] gt_cur;
  logic [CNT_W-1:0] g_last;
  logic [PH_W-1:0]  cand_idx [N_PHASE];
  logic [N_PHASE-1:0] cand_hit;
  logic [PH_W-1:0]  skip_phase;
  logic             skip_found;
  logic [PH_W-1:0]  sel_phase;
  logic [N_SIG-1:0] mask_cur;

  // Preemption forces the block to run even when Go is low.
  assign advance = Go | preempt;
  assign gt_cur  = green_time[phase_reg*CNT_W +: CNT_W];
  assign g_last  = g_reg - 1'b1;

  // Candidate gi is the phase gi+1 steps ahead of the current one, circularly.
  generate
    for (genvar gi = 0; gi < N_PHASE; gi++) begin : g_cand
      logic [PH_W:0] sum;
      assign sum          = {1'b0, phase_reg} + (PH_W + 1)'(gi + 1);
      assign cand_idx[gi] = (sum >= N_PHASE_EXT) ? PH_W'(sum - N_PHASE_EXT) : PH_W'(sum);
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Pick the nearest requesting phase; candidate 0 is also the plain successor.
  always_comb begin
    skip_phase = cand_idx[0];
    skip_found = 1'b0;
    for (int k = N_PHASE - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        skip_phase = cand_idx[k];
        skip_found = 1'b1;
      end
    end
    sel_phase = (SKIP_EN && skip_found) ? skip_phase : cand_idx[0];
  end

  // Next-state, timer, phase and green-latch logic.
  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    phase_next      = phase_reg;
    g_next          = g_reg;
    phase_done_next = 1'b0;
    if (advance) begin
      case (state_reg)
        S_REDYEL: begin
          if (preempt) begin
            state_next = S_YELLOW;
            timer_next = '0;
          end else if (timer_reg == RY_LAST) begin
            state_next = S_GREEN;
            timer_next = '0;
            g_next     = (gt_cur == '0) ? CNT_W'(1) : gt_cur;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        S_GREEN: begin
          if (preempt || timer_reg == g_last) begin
            state_next = S_YELLOW;
            timer_next = '0;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        S_YELLOW: begin
          if (timer_reg == YE_LAST) begin
            state_next = S_ALLRED;
            timer_next = '0;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        S_ALLRED: begin
          if (timer_reg == AR_LAST) begin
            timer_next = '0;
            if (preempt) begin
              state_next = S_HOLD;
            end else begin
              state_next      = S_REDYEL;
              phase_next      = sel_phase;
              phase_done_next = 1'b1;
            end
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        S_HOLD: begin
          timer_next = '0;
          if (!preempt) begin
            state_next = S_ALLRED;
          end
        end
        default: begin
          state_next = S_ALLRED;
          timer_next = '0;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_reg      <= S_ALLRED;
      timer_reg      <= '0;
      phase_reg      <= LAST_PHASE;
      g_reg          <= CNT_W'(1);
      phase_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      phase_reg      <= phase_next;
      g_reg          <= g_next;
      phase_done_reg <= phase_done_next;
    end
  end

  // Heads belonging to the current phase.
  assign mask_cur = PHASE_MASK[phase_reg*N_SIG +: N_SIG];

  generate
    for (genvar gi = 0; gi < N_SIG; gi++) begin : g_head
      // Moore decode of one head from the state and phase registers.
      always_comb begin
        sig[2*gi +: 2] = 2'b10;
        if (mask_cur[gi]) begin
          case (state_reg)
            S_REDYEL: sig[2*gi +: 2] = 2'b11;
            S_GREEN:  sig[2*gi +: 2] = 2'b00;
            S_YELLOW: sig[2*gi +: 2] = 2'b01;
            default:  sig[2*gi +: 2] = 2'b10;
          endcase
        end
      end
    end
  endgenerate

  assign phase      = phase_reg;
  assign state      = state_reg;
  assign phase_done = phase_done_reg;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: the stimulus thread queues the
// hand-derived outputs expected after each clock edge; the monitor thread
// pops one entry per edge and compares it with the DUT outputs.
module tb_traffic_phase_ctrl;

  localparam logic [2:0] AR = 3'd0;
  localparam logic [2:0] RY = 3'd1;
  localparam logic [2:0] GR = 3'd2;
  localparam logic [2:0] YE = 3'd3;
  localparam logic [2:0] HO = 3'd4;

  logic        clk;
  logic        Rst;
  logic        Go;
  logic [23:0] green_time;
  logic [3:0]  req;
  logic        preempt;
  logic [7:0]  sig;
  logic [1:0]  phase;
  logic [2:0]  state;
  logic        phase_done;

  typedef struct {
    logic [2:0] st;
    logic [1:0] ph;
    logic [7:0] sg;
    logic       pd;
    int         id;
  } exp_t;

  exp_t sb_q[$];
  int   vec_id = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  // Hand-decoded lamp words per phase (mask 16'h18C3: {0,1}, {2,3}, {3}, {0}).
  logic [7:0] ry_sig [4];
  logic [7:0] gr_sig [4];
  logic [7:0] ye_sig [4];

  traffic_phase_ctrl dut (
    .clk        (clk),
    .Rst        (Rst),
    .Go         (Go),
    .green_time (green_time),
    .req        (req),
    .preempt    (preempt),
    .sig        (sig),
    .phase      (phase),
    .state      (state),
    .phase_done (phase_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Queue n edges' worth of expectations, one per clock, inputs held.
  task automatic seg(input int n, input logic [2:0] st, input logic [1:0] ph,
                     input logic [7:0] sg, input logic pd_first);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.st = st;
      e.ph = ph;
      e.sg = sg;
      e.pd = (i == 0) ? pd_first : 1'b0;
      e.id = vec_id;
      vec_id++;
      sb_q.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic phase_run(input int p, input int g);
    seg(2, RY, 2'(p), ry_sig[p], 1'b1);
    seg(g, GR, 2'(p), gr_sig[p], 1'b0);
    seg(2, YE, 2'(p), ye_sig[p], 1'b0);
    seg(1, AR, 2'(p), 8'hAA, 1'b0);
  endtask

  // Monitor: one comparison per clock edge while expectations are pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk_cnt++;
        if (state !== e.st || phase !== e.ph || sig !== e.sg || phase_done !== e.pd) begin
          $display("FAIL vec%0d: got state=%0d phase=%0d sig=%h pd=%b, expected state=%0d phase=%0d sig=%h pd=%b",
                   e.id, state, phase, sig, phase_done, e.st, e.ph, e.sg, e.pd);
        end else begin
          pass_cnt++;
          $display("vec%0d ok: state=%0d phase=%0d sig=%h pd=%b", e.id, state, phase, sig, phase_done);
        end
      end
    end
  end

  initial begin
    ry_sig[0] = 8'hAF; gr_sig[0] = 8'hA0; ye_sig[0] = 8'hA5;
    ry_sig[1] = 8'hFA; gr_sig[1] = 8'h0A; ye_sig[1] = 8'h5A;
    ry_sig[2] = 8'hEA; gr_sig[2] = 8'h2A; ye_sig[2] = 8'h6A;
    ry_sig[3] = 8'hAB; gr_sig[3] = 8'hA8; ye_sig[3] = 8'hA9;

    Rst        = 1'b1;
    Go         = 1'b1;
    req        = 4'b0000;
    preempt    = 1'b0;
    green_time = {4{6'd3}};
    @(negedge clk);

    // Reset state.
    seg(1, AR, 2'd3, 8'hAA, 1'b0);
    Rst = 1'b0;

    // Free run through all four phases.
    phase_run(0, 3);
    phase_run(1, 3);
    phase_run(2, 3);
    phase_run(3, 3);

    // Freeze for 20 cycles after the first green cycle of phase 0.
    seg(2, RY, 2'd0, 8'hAF, 1'b1);
    seg(1, GR, 2'd0, 8'hA0, 1'b0);
    Go = 1'b0;
    seg(20, GR, 2'd0, 8'hA0, 1'b0);
    Go = 1'b1;
    seg(2, GR, 2'd0, 8'hA0, 1'b0);
    seg(2, YE, 2'd0, 8'hA5, 1'b0);
    seg(1, AR, 2'd0, 8'hAA, 1'b0);

    // Demand from phase 3 only: phases 1 and 2 skipped.
    req = 4'b1000;
    phase_run(3, 3);

    // Demand from phase 0 only, zero green time acts as one cycle.
    req = 4'b0001;
    green_time[5:0] = 6'd0;
    phase_run(0, 1);

    // Phase 0 repeats; a mid-green change of green_time is ignored.
    green_time[5:0] = 6'd5;
    seg(2, RY, 2'd0, 8'hAF, 1'b1);
    seg(2, GR, 2'd0, 8'hA0, 1'b0);
    green_time[5:0] = 6'd1;
    seg(3, GR, 2'd0, 8'hA0, 1'b0);
    seg(2, YE, 2'd0, 8'hA5, 1'b0);
    seg(1, AR, 2'd0, 8'hAA, 1'b0);

    // Preemption at green cycle 1 of phase 1, held for 10 hold cycles.
    req = 4'b0000;
    seg(2, RY, 2'd1, 8'hFA, 1'b1);
    seg(1, GR, 2'd1, 8'h0A, 1'b0);
    preempt = 1'b1;
    seg(2, YE, 2'd1, 8'h5A, 1'b0);
    seg(1, AR, 2'd1, 8'hAA, 1'b0);
    seg(10, HO, 2'd1, 8'hAA, 1'b0);
    preempt = 1'b0;
    seg(1, AR, 2'd1, 8'hAA, 1'b0);
    phase_run(2, 3);

    // Reset during YELLOW.
    seg(2, RY, 2'd3, 8'hAB, 1'b1);
    seg(3, GR, 2'd3, 8'hA8, 1'b0);
    seg(1, YE, 2'd3, 8'hA9, 1'b0);
    Rst = 1'b1;
    seg(1, AR, 2'd3, 8'hAA, 1'b0);
    Rst = 1'b0;

    // Reset during HOLD with preemption still requested.
    preempt = 1'b1;
    seg(3, HO, 2'd3, 8'hAA, 1'b0);
    Rst = 1'b1;
    seg(1, AR, 2'd3, 8'hAA, 1'b0);
    Rst = 1'b0;
    preempt = 1'b0;
    seg(2, RY, 2'd0, 8'hAF, 1'b1);

    // Every queued expectation must have been consumed.
    @(posedge clk);
    #2;
    chk_cnt++;
    if (sb_q.size() != 0) begin
      $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
    end else begin
      pass_cnt++;
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
